// File: rtl/wb_stage_ng_pkg.sv
// Shared constants for the write-back stage: load funct3 encodings, result source indices
// and the source-select width helper.
package wb_stage_ng_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int SRC_ALU  = 0;
    localparam int SRC_LOAD = 1;
    localparam int SRC_PC4  = 2;
    localparam int SRC_IMM  = 3;

    function automatic int sel_width(input int nsrc);
        return (nsrc > 1) ? $clog2(nsrc) : 1;
    endfunction

endpackage

// File: rtl/wb_stage_ng_if.sv
// MEM/WB bundle plus regfile write port, forwarding tap and retire count.
interface wb_stage_ng_if
    import wb_stage_ng_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NSRC  = 4,
    parameter int RAW   = 5,
    parameter int CNT_W = 64
) ();
    localparam int SEL_W = sel_width(NSRC);

    logic                 valid;
    logic                 stall;
    logic                 flush;
    logic                 reg_src;
    logic [RAW-1:0]       rd;
    logic [SEL_W-1:0]     result_src;
    logic [NSRC*XLEN-1:0] src_data;
    logic [2:0]           load_type;
    logic [1:0]           addr_lo;

    logic                 ready;
    logic                 wb_we;
    logic [RAW-1:0]       wb_rd;
    logic [XLEN-1:0]      wb_data;
    logic                 fwd_valid;
    logic                 misalign;
    logic [CNT_W-1:0]     instret;

    modport master (
        output valid, stall, flush, reg_src, rd, result_src, src_data, load_type, addr_lo,
        input  ready, wb_we, wb_rd, wb_data, fwd_valid, misalign, instret
    );

    modport slave (
        input  valid, stall, flush, reg_src, rd, result_src, src_data, load_type, addr_lo,
        output ready, wb_we, wb_rd, wb_data, fwd_valid, misalign, instret
    );
endinterface

// File: rtl/wb_stage_ng_load_align.sv
// Combinational load formatter: picks the byte/half lane from the low address bits,
// sign- or zero-extends it, and flags misaligned halfword/word accesses.
module wb_load_align
    import wb_stage_ng_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] result,
    output logic            misalign
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] zext8(input logic [7:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] zext16(input logic [15:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = data[7:0];
            2'd1:    byte_lane = data[15:8];
            2'd2:    byte_lane = data[23:16];
            default: byte_lane = data[31:24];
        endcase
        half_lane = addr_lo[1] ? data[31:16] : data[15:0];

        result   = '0;
        misalign = 1'b0;
        // Misaligned accesses still return the formatted lane; the trap unit decides.
        case (funct3)
            F3_LB:  result = sext8(byte_lane);
            F3_LBU: result = zext8(byte_lane);
            F3_LH: begin
                result   = sext16(half_lane);
                misalign = addr_lo[0];
            end
            F3_LHU: begin
                result   = zext16(half_lane);
                misalign = addr_lo[0];
            end
            F3_LW: begin
                result   = sext32(data[31:0]);
                misalign = (addr_lo != 2'd0);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/wb_stage_ng.sv
// Registered write-back stage: source mux and load formatting at capture, one regfile write
// and one retire per held entry regardless of how long the hazard unit stalls it.
module wb_stage_ng
    import wb_stage_ng_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NSRC     = 4,
    parameter int LOAD_IDX = SRC_LOAD,
    parameter int RAW      = 5,
    parameter int CNT_W    = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_stage_ng_if.slave  bus
);
    localparam int SEL_W = sel_width(NSRC);
    localparam logic [SEL_W-1:0] LOAD_SEL = SEL_W'(LOAD_IDX);

    logic [XLEN-1:0]  src_p0;
    logic [XLEN-1:0]  fmt_p0;
    logic [XLEN-1:0]  wb_p0;
    logic             fmt_mis_p0;
    logic             is_load_p0;
    logic             mis_p0;

    logic             vld_p1;
    logic             done_p1;
    logic             regsrc_p1;
    logic [RAW-1:0]   rd_p1;
    logic [XLEN-1:0]  wb_p1;
    logic             mis_p1;
    logic             fwd_p1;
    logic [CNT_W-1:0] instret_q;

    // Stage p0: source select and load formatting on the incoming bundle.
    always_comb begin
        src_p0 = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.result_src == SEL_W'(k)) src_p0 = bus.src_data[k*XLEN +: XLEN];
        end
    end

    wb_load_align #(.XLEN(XLEN)) u_align (
        .data     (src_p0),
        .funct3   (bus.load_type),
        .addr_lo  (bus.addr_lo),
        .result   (fmt_p0),
        .misalign (fmt_mis_p0)
    );

    assign is_load_p0 = (bus.result_src == LOAD_SEL);
    assign wb_p0      = is_load_p0 ? fmt_p0 : src_p0;
    assign mis_p0     = is_load_p0 & fmt_mis_p0;

    // Stage p1: held entry; flush loads a bubble ahead of both stall and accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            done_p1   <= 1'b0;
            regsrc_p1 <= 1'b0;
            instret_q <= '0;
        end else begin
            if (vld_p1 && !done_p1) instret_q <= instret_q + CNT_W'(1);
            if (bus.flush) begin
                vld_p1  <= 1'b0;
                done_p1 <= 1'b0;
            end else if (!bus.stall) begin
                vld_p1    <= bus.valid;
                done_p1   <= 1'b0;
                regsrc_p1 <= bus.reg_src;
            end else begin
                done_p1 <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!bus.stall && !bus.flush) begin
            rd_p1  <= bus.rd;
            wb_p1  <= wb_p0;
            mis_p1 <= mis_p0;
        end
    end

    assign fwd_p1        = vld_p1 & regsrc_p1 & (rd_p1 != '0);
    assign bus.ready     = ~bus.stall;
    assign bus.wb_we     = fwd_p1 & ~done_p1;
    assign bus.fwd_valid = fwd_p1;
    assign bus.wb_rd     = vld_p1 ? rd_p1 : '0;
    assign bus.wb_data   = fwd_p1 ? wb_p1 : '0;
    assign bus.misalign  = vld_p1 & mis_p1;
    assign bus.instret   = instret_q;
endmodule

// File: tb/tb_wb_stage_ng.sv
// Bench for wb_stage_ng: directed scenarios plus a randomized run against an entry-level model.
module tb_wb_stage_ng;
    import wb_stage_ng_pkg::*;

    localparam int XLEN     = 32;
    localparam int NSRC     = 5;
    localparam int LOAD_IDX = 1;
    localparam int RAW      = 5;
    localparam int CNT_W    = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_stage_ng_if #(.XLEN(XLEN), .NSRC(NSRC), .RAW(RAW), .CNT_W(CNT_W)) bus ();

    wb_stage_ng #(
        .XLEN(XLEN), .NSRC(NSRC), .LOAD_IDX(LOAD_IDX), .RAW(RAW), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] src [NSRC];
    logic [63:0] exp_ret;

    task automatic drive(input bit v, input bit st, input bit fl, input bit rs,
                         input int rd, input int sel, input int ft, input int lo);
        bus.valid      = v;
        bus.stall      = st;
        bus.flush      = fl;
        bus.reg_src    = rs;
        bus.rd         = 5'(rd);
        bus.result_src = 3'(sel);
        bus.load_type  = 3'(ft);
        bus.addr_lo    = 2'(lo);
        for (int k = 0; k < NSRC; k++) bus.src_data[k*XLEN +: XLEN] = src[k];
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected write data computed straight from the load rules with integer arithmetic.
    function automatic logic [31:0] ref_value(input int sel, input int ft, input int lo);
        logic [31:0] w;
        int b;
        if (sel >= NSRC) return 32'h0;
        w = src[sel];
        if (sel != LOAD_IDX) return w;
        case (ft)
            0: begin b = int'((w >> (8*lo)) & 32'hFF); if (b >= 128) b -= 256; return 32'(b); end
            4: return (w >> (8*lo)) & 32'hFF;
            1: begin b = int'((w >> (16*(lo/2))) & 32'hFFFF); if (b >= 32768) b -= 65536; return 32'(b); end
            5: return (w >> (16*(lo/2))) & 32'hFFFF;
            2: return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_mis(input int sel, input int ft, input int lo);
        if (sel != LOAD_IDX) return 1'b0;
        if ((ft == 1 || ft == 5) && (lo % 2 == 1)) return 1'b1;
        if (ft == 2 && lo != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NSRC; k++) src[k] = 32'h0;
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        #2;
        checks++; if (bus.wb_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.wb_we); end
        checks++; if (bus.wb_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.wb_data); end
        checks++; if (bus.fwd_valid !== 1'b0 || bus.misalign !== 1'b0 || bus.wb_rd !== 5'd0) begin failures++; $display("FAIL reset_ctl got=%b%b%h exp=000", bus.fwd_valid, bus.misalign, bus.wb_rd); end
        checks++; if (bus.instret !== 64'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", bus.instret); end
        checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL reset_ready_stall got=%b exp=0", bus.ready); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_ret = 64'd0;
    endtask

    task automatic test_lb();
        src[1] = 32'h80FF_1234;
        drive(1, 0, 0, 1, 5, 1, 0, 3); tick();
        checks++; if (bus.wb_we !== 1'b1) begin failures++; $display("FAIL lb_we got=%b exp=1", bus.wb_we); end
        checks++; if (bus.wb_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", bus.wb_data); end
        checks++; if (bus.wb_rd !== 5'd5 || bus.misalign !== 1'b0) begin failures++; $display("FAIL lb_rd_mis got=%0d/%b exp=5/0", bus.wb_rd, bus.misalign); end
        checks++; if (bus.instret !== exp_ret) begin failures++; $display("FAIL lb_instret_first got=%0d exp=%0d", bus.instret, exp_ret); end
        exp_ret++;
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++; if (bus.wb_we !== 1'b0 || bus.instret !== exp_ret) begin failures++; $display("FAIL lb_after got=%b/%0d exp=0/%0d", bus.wb_we, bus.instret, exp_ret); end
    endtask

    task automatic test_half();
        drive(1, 0, 0, 1, 6, 1, 5, 2); tick();
        checks++; if (bus.wb_data !== 32'h0000_80FF || bus.wb_we !== 1'b1) begin failures++; $display("FAIL lhu_data got=%h/%b exp=000080ff/1", bus.wb_data, bus.wb_we); end
        exp_ret++;
        drive(1, 0, 0, 1, 7, 1, 1, 1); tick();
        checks++; if (bus.wb_data !== 32'h0000_1234 || bus.wb_we !== 1'b1) begin failures++; $display("FAIL lh_mis_data got=%h/%b exp=00001234/1", bus.wb_data, bus.wb_we); end
        checks++; if (bus.misalign !== 1'b1) begin failures++; $display("FAIL lh_misalign got=%b exp=1", bus.misalign); end
        checks++; if (bus.instret !== exp_ret) begin failures++; $display("FAIL half_instret got=%0d exp=%0d", bus.instret, exp_ret); end
        exp_ret++;
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++; if (bus.misalign !== 1'b0 || bus.instret !== exp_ret) begin failures++; $display("FAIL half_after got=%b/%0d exp=0/%0d", bus.misalign, bus.instret, exp_ret); end
    endtask

    task automatic test_rd_zero();
        src[0] = 32'hDEAD_BEEF;
        drive(1, 0, 0, 1, 0, 0, 0, 0); tick();
        checks++; if (bus.wb_we !== 1'b0 || bus.fwd_valid !== 1'b0) begin failures++; $display("FAIL rd0_ctl got=%b%b exp=00", bus.wb_we, bus.fwd_valid); end
        checks++; if (bus.wb_data !== 32'h0) begin failures++; $display("FAIL rd0_data got=%h exp=0", bus.wb_data); end
        exp_ret++;
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++; if (bus.instret !== exp_ret) begin failures++; $display("FAIL rd0_instret got=%0d exp=%0d", bus.instret, exp_ret); end
    endtask

    task automatic test_stall();
        int pulses = 0;
        src[2] = 32'h0000_0104;
        drive(1, 0, 0, 1, 1, 2, 0, 0); tick();
        src[0] = 32'h1111_2222;
        for (int i = 0; i < 4; i++) begin
            if (bus.wb_we === 1'b1) pulses++;
            checks++; if (bus.fwd_valid !== 1'b1 || bus.wb_data !== 32'h104 || bus.wb_rd !== 5'd1) begin failures++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%0d exp=1/104/1", i, bus.fwd_valid, bus.wb_data, bus.wb_rd); end
            if (i < 3) begin drive(1, 1, 0, 1, 9, 0, 0, 0); tick(); end
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL stall_pulses got=%0d exp=1", pulses); end
        exp_ret++;
        checks++; if (bus.instret !== exp_ret) begin failures++; $display("FAIL stall_instret got=%0d exp=%0d", bus.instret, exp_ret); end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++; if (bus.wb_we !== 1'b0 || bus.instret !== exp_ret) begin failures++; $display("FAIL stall_release got=%b/%0d exp=0/%0d", bus.wb_we, bus.instret, exp_ret); end
    endtask

    task automatic test_flush();
        drive(1, 1, 1, 1, 3, 0, 0, 0); tick();
        checks++; if (bus.wb_we !== 1'b0 || bus.fwd_valid !== 1'b0 || bus.wb_rd !== 5'd0) begin failures++; $display("FAIL flush_first got=%b%b/%0d exp=00/0", bus.wb_we, bus.fwd_valid, bus.wb_rd); end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++; if (bus.instret !== exp_ret) begin failures++; $display("FAIL flush_instret got=%0d exp=%0d", bus.instret, exp_ret); end
        drive(1, 0, 0, 1, 6, 0, 0, 0); tick();
        exp_ret++;
        drive(1, 1, 1, 1, 7, 0, 0, 0); tick();
        checks++; if (bus.fwd_valid !== 1'b0 || bus.wb_we !== 1'b0) begin failures++; $display("FAIL flush_held got=%b%b exp=00", bus.fwd_valid, bus.wb_we); end
        checks++; if (bus.instret !== exp_ret) begin failures++; $display("FAIL flush_held_instret got=%0d exp=%0d", bus.instret, exp_ret); end
    endtask

    task automatic test_reset_mid_stall();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin drive(1, 0, 0, 1, 2, 0, 0, 0); tick(); end
        drive(1, 1, 0, 1, 2, 0, 0, 0); tick();
        checks++; if (bus.instret !== 64'd10 || bus.fwd_valid !== 1'b1 || bus.wb_we !== 1'b0) begin failures++; $display("FAIL pre_reset got=%0d/%b%b exp=10/10", bus.instret, bus.fwd_valid, bus.wb_we); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.instret !== 64'd0) begin failures++; $display("FAIL async_instret got=%0d exp=0", bus.instret); end
        checks++; if (bus.fwd_valid !== 1'b0 || bus.wb_we !== 1'b0 || bus.wb_data !== 32'h0 || bus.wb_rd !== 5'd0) begin failures++; $display("FAIL async_outputs got=%b%b/%h/%0d exp=00/0/0", bus.fwd_valid, bus.wb_we, bus.wb_data, bus.wb_rd); end
        @(negedge clk);
        rst_n = 1'b1;
        src[0] = 32'hCAFE_F00D;
        drive(1, 0, 0, 1, 4, 7, 0, 0); tick();
        checks++; if (bus.wb_we !== 1'b1 || bus.wb_data !== 32'h0 || bus.wb_rd !== 5'd4) begin failures++; $display("FAIL src7 got=%b/%h/%0d exp=1/0/4", bus.wb_we, bus.wb_data, bus.wb_rd); end
        drive(1, 0, 0, 1, 8, 5, 0, 0); tick();
        checks++; if (bus.wb_we !== 1'b1 || bus.wb_data !== 32'h0) begin failures++; $display("FAIL src5 got=%b/%h exp=1/0", bus.wb_we, bus.wb_data); end
    endtask

    task automatic test_random();
        bit m_valid = 0, m_first = 0, m_regsrc = 0, m_mis = 0;
        int m_rd = 0;
        logic [31:0] m_data = 32'h0;
        logic [63:0] m_ret = 64'd0;
        bit cur_stall = 0;
        bit e_fwd;
        bit v, st, fl, rs;
        int rd, sel, ft, lo;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        rst_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            e_fwd = m_valid && m_regsrc && (m_rd != 0);
            checks++; if (bus.wb_we !== (e_fwd && m_first)) begin failures++; $display("FAIL rnd_we n=%0d got=%b exp=%b", n, bus.wb_we, e_fwd && m_first); end
            checks++; if (bus.fwd_valid !== e_fwd) begin failures++; $display("FAIL rnd_fwd n=%0d got=%b exp=%b", n, bus.fwd_valid, e_fwd); end
            checks++; if (bus.wb_data !== (e_fwd ? m_data : 32'h0)) begin failures++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, bus.wb_data, e_fwd ? m_data : 32'h0); end
            checks++; if (bus.wb_rd !== (m_valid ? 5'(m_rd) : 5'd0)) begin failures++; $display("FAIL rnd_rd n=%0d got=%0d exp=%0d", n, bus.wb_rd, m_valid ? m_rd : 0); end
            checks++; if (bus.misalign !== (m_valid && m_mis)) begin failures++; $display("FAIL rnd_mis n=%0d got=%b exp=%b", n, bus.misalign, m_valid && m_mis); end
            checks++; if (bus.instret !== m_ret) begin failures++; $display("FAIL rnd_instret n=%0d got=%0d exp=%0d", n, bus.instret, m_ret); end
            checks++; if (bus.ready !== !cur_stall) begin failures++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, bus.ready, !cur_stall); end

            v   = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            rs  = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
            sel = int'($urandom_range(0, 7));
            ft  = int'($urandom_range(0, 7));
            lo  = int'($urandom_range(0, 3));
            for (int k = 0; k < NSRC; k++) src[k] = $urandom;
            drive(v, st, fl, rs, rd, sel, ft, lo);

            // Each entry retires once, at the end of its first held cycle.
            if (m_valid && m_first) m_ret++;
            if (fl) begin
                m_valid = 0; m_first = 0;
            end else if (!st) begin
                m_valid = v; m_first = 1; m_regsrc = rs; m_rd = rd;
                m_data = ref_value(sel, ft, lo); m_mis = ref_mis(sel, ft, lo);
            end else begin
                m_first = 0;
            end
            cur_stall = st;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_half();
        test_rd_zero();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
